sd_cmd_engine: RTL and testbench
================================

Name: sd_cmd_engine

Overview:
Command-level sequencer that sits directly upstream of the byte-level SPI master and drives its byte interface (data_in, data_out, w_data, w_conf, ss_in, busy).
- Programs the SCLK divider and issues the SD power-up dummy clocks.
- Serialises a 6-byte SD command frame, polls for the R1 response and optionally captures a 4-byte R3/R7 tail.
- Host logic (SD init FSM, block reader) sees one start/done handshake per command.

Parameters:
POLL_MAX, 8, max 0xFF poll bytes sent while waiting for R1 (MSB=0); range 1..255
INIT_CYCLES, 1024, clk cycles ss_in held high during the init dummy-clock phase
XFER_TIMEOUT, 64, clk cycles allowed for spi_busy to rise after a w_data pulse

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
init_start  in  1  one-cycle pulse: program divider, then run dummy clocks
clk_div  in  8  divider value written to the SPI master on init_start
cmd_start  in  1  one-cycle pulse: issue command
cmd_index  in  6  SD command index
cmd_arg  in  32  command argument
cmd_crc  in  7  CRC7 of the frame
cmd_ext  in  1  1: capture 4 extra response bytes (R3/R7)
busy  out  1  engine active
done  out  1  one-cycle pulse at end of init or command
err_timeout  out  1  R1 poll exhausted or SPI handshake lost; valid with done
resp_r1  out  8  R1 byte (0xFF on timeout)
resp_ext  out  32  extra response bytes, MSB first
spi_data_in  out  8  byte to SPI master
spi_data_out  in  8  byte received by SPI master
spi_w_data  out  1  write-data pulse to SPI master
spi_w_conf  out  1  write-config pulse to SPI master
spi_ss_in  out  1  SS/free-run control to SPI master
spi_busy  in  1  SPI master busy

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0 except resp_r1=0xFF. Reset mid-transfer abandons the frame. No SPI strobe is issued until rst is released.
- IDLE: init_start takes priority over cmd_start when both are asserted. Both inputs are ignored while busy=1.
- Init path:
  - CONF: one cycle with spi_w_conf=1 and spi_data_in=clk_div.
  - INIT_CLK: spi_ss_in=1 for exactly INIT_CYCLES cycles.
  - DONE: done=1 and err_timeout=0.
- Command path:
  - Frame bytes are latched at cmd_start: b0={2'b01,cmd_index}; b1..b4=cmd_arg[31:24]..[7:0]; b5={cmd_crc,1'b1}.
  - SEND: for each byte, pulse spi_w_data for 1 cycle with spi_data_in=byte. Enter WAIT_RISE until spi_busy=1, then WAIT_FALL until spi_busy=0. The received byte is spi_data_out, sampled on the cycle busy falls.
  - WAIT_RISE: if XFER_TIMEOUT cycles elapse without spi_busy=1, go to DONE with err_timeout=1.
  - POLL: send 0xFF. If the received byte has bit7=0, latch resp_r1. Otherwise repeat, up to POLL_MAX bytes; on exhaustion set err_timeout=1 and resp_r1=0xFF.
  - EXT (cmd_ext=1 and R1 valid): send 4×0xFF and shift received bytes into resp_ext MSB first.
  - GAP: send one trailing 0xFF (Ncr spacing). Its result is discarded.
  - DONE: done=1 for one cycle. busy falls in the same cycle; IDLE follows.
- busy rises the cycle after the accepted start.
- Counters:
  - Byte index: 3 bits.
  - Poll count: 8 bits; saturates, never wraps.
  - Cycle counter: 32 bits; reused for INIT_CYCLES and XFER_TIMEOUT.
- spi_ss_in=0 throughout the command path.
- resp_ext holds its previous value when cmd_ext=0.
- A one-cycle spi_busy glitch still counts as a complete transfer.

Decomposition:
- Package sd_cmd_pkg:
  - State enum: IDLE, CONF, INIT_CLK, SEND, WAIT_RISE, WAIT_FALL, POLL, EXT, GAP, DONE.
  - Constants: SD_FILL_BYTE=8'hFF, SD_START_BITS=2'b01, FRAME_LEN=6, EXT_LEN=4.
- Sub-module spi_byte_xfer: w_data pulse / rise / fall handshake plus timeout counter. Returns rx byte, xfer_done and xfer_err.

Test Plan:
- Init: clk_div=3, INIT_CYCLES=16 -> one spi_w_conf cycle with data 0x03; spi_ss_in=1 for exactly 16 cycles; done=1 and err_timeout=0.
- CMD0: idx=0, arg=0, crc=0x4A -> master receives 40 00 00 00 00 95; slave returns 0xFF, 0xFF, 0x01 -> resp_r1=0x01 after 3 polls, then one GAP byte, done.
- CMD8: idx=8, arg=0x000001AA, crc=0x43, cmd_ext=1; slave R1=0x01 then 00 00 01 AA -> resp_ext=0x000001AA and first byte 0x48.
- Poll timeout: slave always 0xFF, POLL_MAX=8 -> exactly 8 poll bytes, err_timeout=1, resp_r1=0xFF, no EXT/GAP.
- Lost handshake: spi_busy tied 0 -> done with err_timeout=1 after XFER_TIMEOUT cycles. Reset mid-frame -> outputs at reset values; next cmd_start runs cleanly.
- cmd_start pulsed while busy=1 -> ignored; init_start+cmd_start in the same cycle -> init runs.

Source files
------------

// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD command engine.
// Also holds the command-frame packing helpers.
package sd_cmd_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CONF,
    INIT_CLK,
    SEND,
    WAIT_RISE,
    WAIT_FALL,
    POLL,
    EXT,
    GAP,
    DONE
  } state_t;

  localparam logic [7:0] SD_FILL_BYTE  = 8'hFF;
  localparam logic [1:0] SD_START_BITS = 2'b01;
  localparam int         FRAME_LEN     = 6;
  localparam int         EXT_LEN       = 4;

  // Six-byte frame: start bits, index, argument MSB first, CRC7 and end bit.
  function automatic logic [47:0] build_frame(input logic [5:0]  index,
                                               input logic [31:0] arg,
                                               input logic [6:0]  crc);
    return {SD_START_BITS, index, arg, crc, 1'b1};
  endfunction

  function automatic logic [7:0] frame_byte(input logic [47:0] frame,
                                            input logic [2:0]  idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = frame[47:40];
      3'd1:    b = frame[39:32];
      3'd2:    b = frame[31:24];
      3'd3:    b = frame[23:16];
      3'd4:    b = frame[15:8];
      3'd5:    b = frame[7:0];
      default: b = SD_FILL_BYTE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_byte_xfer.sv
// One byte exchange with the SPI master: w_data pulse, wait for busy to rise
// (bounded by XFER_TIMEOUT), then wait for busy to fall and hand back the rx byte.
module spi_byte_xfer
  import sd_cmd_pkg::*;
#(
  parameter int XFER_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       spi_busy,
  input  logic [7:0] spi_data_out,
  output logic       spi_w_data,
  output logic [7:0] spi_data_in,
  output logic [7:0] rx_byte,
  output logic       xfer_done,
  output logic       xfer_err
);

  state_t      state, next_state;
  logic [31:0] cyc_cnt;
  logic [7:0]  tx_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cyc_cnt <= '0;
      tx_reg  <= '0;
    end else begin
      state <= next_state;
      if (start)
        tx_reg <= tx_byte;
      if (state == SEND)
        cyc_cnt <= '0;
      else if (state == WAIT_RISE)
        cyc_cnt <= cyc_cnt + 32'd1;
    end
  end

  // A new start may arrive on the completing cycle so bytes chain back to back.
  always_comb begin
    next_state = state;
    xfer_done  = 1'b0;
    xfer_err   = 1'b0;
    case (state)
      IDLE:      if (start) next_state = SEND;
      SEND:      next_state = WAIT_RISE;
      WAIT_RISE: begin
        if (spi_busy) begin
          next_state = WAIT_FALL;
        end else if (cyc_cnt == 32'(XFER_TIMEOUT - 1)) begin
          xfer_err   = 1'b1;
          next_state = IDLE;
        end
      end
      WAIT_FALL: begin
        if (!spi_busy) begin
          xfer_done  = 1'b1;
          next_state = start ? SEND : IDLE;
        end
      end
      default:   next_state = IDLE;
    endcase
  end

  assign spi_w_data  = (state == SEND);
  assign spi_data_in = tx_reg;
  assign rx_byte     = spi_data_out;

endmodule

// File: rtl/sd_cmd_engine.sv
// SD command sequencer: divider setup plus dummy clocks, or a full command
// frame with R1 polling, optional R3/R7 tail and the trailing Ncr byte.
module sd_cmd_engine
  import sd_cmd_pkg::*;
#(
  parameter int POLL_MAX     = 8,
  parameter int INIT_CYCLES  = 1024,
  parameter int XFER_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_start,
  input  logic [7:0]  clk_div,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  input  logic        cmd_ext,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  output logic [7:0]  resp_r1,
  output logic [31:0] resp_ext,
  output logic [7:0]  spi_data_in,
  input  logic [7:0]  spi_data_out,
  output logic        spi_w_data,
  output logic        spi_w_conf,
  output logic        spi_ss_in,
  input  logic        spi_busy
);

  state_t      state, next_state;
  logic [47:0] frame;
  logic [7:0]  div_reg;
  logic        ext_en;
  logic [2:0]  idx;
  logic [7:0]  poll_cnt;
  logic [31:0] cyc_cnt;
  logic        err_reg;
  logic        xfer_start, xfer_done, xfer_err;
  logic [7:0]  tx_byte, rx_byte, xfer_data_in;

  spi_byte_xfer #(.XFER_TIMEOUT(XFER_TIMEOUT)) u_xfer (
    .clk          (clk),
    .rst          (rst),
    .start        (xfer_start),
    .tx_byte      (tx_byte),
    .spi_busy     (spi_busy),
    .spi_data_out (spi_data_out),
    .spi_w_data   (spi_w_data),
    .spi_data_in  (xfer_data_in),
    .rx_byte      (rx_byte),
    .xfer_done    (xfer_done),
    .xfer_err     (xfer_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      frame    <= '0;
      div_reg  <= '0;
      ext_en   <= 1'b0;
      idx      <= '0;
      poll_cnt <= '0;
      cyc_cnt  <= '0;
      err_reg  <= 1'b0;
      resp_r1  <= SD_FILL_BYTE;
      resp_ext <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (init_start) begin
            div_reg <= clk_div;
            err_reg <= 1'b0;
          end else if (cmd_start) begin
            frame    <= build_frame(cmd_index, cmd_arg, cmd_crc);
            ext_en   <= cmd_ext;
            idx      <= '0;
            poll_cnt <= '0;
            err_reg  <= 1'b0;
            resp_r1  <= SD_FILL_BYTE;
          end
        end
        CONF:     cyc_cnt <= '0;
        INIT_CLK: cyc_cnt <= cyc_cnt + 32'd1;
        SEND, POLL, EXT, GAP: begin
          if (xfer_err) begin
            err_reg <= 1'b1;
            resp_r1 <= SD_FILL_BYTE;
          end else if (xfer_done) begin
            if (state == SEND) begin
              idx <= (idx == 3'(FRAME_LEN - 1)) ? 3'd0 : idx + 3'd1;
            end else if (state == POLL) begin
              if (!rx_byte[7]) begin
                resp_r1 <= rx_byte;
                idx     <= '0;
              end else begin
                if (poll_cnt != 8'hFF)
                  poll_cnt <= poll_cnt + 8'd1;
                if (poll_cnt == 8'(POLL_MAX - 1)) begin
                  err_reg <= 1'b1;
                  resp_r1 <= SD_FILL_BYTE;
                end
              end
            end else if (state == EXT) begin
              resp_ext <= {resp_ext[23:0], rx_byte};
              idx      <= idx + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // The next byte is launched on the same cycle the previous one completes.
  always_comb begin
    next_state = state;
    xfer_start = 1'b0;
    tx_byte    = SD_FILL_BYTE;
    case (state)
      IDLE: begin
        if (init_start) begin
          next_state = CONF;
        end else if (cmd_start) begin
          next_state = SEND;
          xfer_start = 1'b1;
          tx_byte    = {SD_START_BITS, cmd_index};
        end
      end
      CONF:     next_state = INIT_CLK;
      INIT_CLK: if (cyc_cnt == 32'(INIT_CYCLES - 1)) next_state = DONE;
      SEND: begin
        if (xfer_err) begin
          next_state = DONE;
        end else if (xfer_done) begin
          xfer_start = 1'b1;
          if (idx == 3'(FRAME_LEN - 1))
            next_state = POLL;
          else
            tx_byte = frame_byte(frame, idx + 3'd1);
        end
      end
      POLL: begin
        if (xfer_err) begin
          next_state = DONE;
        end else if (xfer_done) begin
          if (!rx_byte[7]) begin
            xfer_start = 1'b1;
            next_state = ext_en ? EXT : GAP;
          end else if (poll_cnt == 8'(POLL_MAX - 1)) begin
            next_state = DONE;
          end else begin
            xfer_start = 1'b1;
          end
        end
      end
      EXT: begin
        if (xfer_err) begin
          next_state = DONE;
        end else if (xfer_done) begin
          xfer_start = 1'b1;
          if (idx == 3'(EXT_LEN - 1))
            next_state = GAP;
        end
      end
      GAP:     if (xfer_err || xfer_done) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy        = (state != IDLE) && (state != DONE);
  assign done        = (state == DONE);
  assign err_timeout = err_reg;
  assign spi_w_conf  = (state == CONF);
  assign spi_ss_in   = (state == INIT_CLK);
  assign spi_data_in = (state == CONF) ? div_reg : xfer_data_in;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Scoreboard bench for sd_cmd_engine with a behavioural SPI byte-master model.
// Stimulus pushes expected tx bytes and command results; monitors pop and compare.
module tb_sd_cmd_engine;

  localparam int P_POLL = 8;
  localparam int P_INIT = 16;
  localparam int P_TO   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        init_start = 1'b0;
  logic [7:0]  clk_div = '0;
  logic        cmd_start = 1'b0;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic [6:0]  cmd_crc = '0;
  logic        cmd_ext = 1'b0;
  logic        busy, done, err_timeout;
  logic [7:0]  resp_r1;
  logic [31:0] resp_ext;
  logic [7:0]  spi_data_in;
  logic [7:0]  spi_data_out = 8'hFF;
  logic        spi_w_data, spi_w_conf, spi_ss_in;
  logic        spi_busy = 1'b0;

  always #5 clk = ~clk;

  sd_cmd_engine #(.POLL_MAX(P_POLL), .INIT_CYCLES(P_INIT), .XFER_TIMEOUT(P_TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .init_start   (init_start),
    .clk_div      (clk_div),
    .cmd_start    (cmd_start),
    .cmd_index    (cmd_index),
    .cmd_arg      (cmd_arg),
    .cmd_crc      (cmd_crc),
    .cmd_ext      (cmd_ext),
    .busy         (busy),
    .done         (done),
    .err_timeout  (err_timeout),
    .resp_r1      (resp_r1),
    .resp_ext     (resp_ext),
    .spi_data_in  (spi_data_in),
    .spi_data_out (spi_data_out),
    .spi_w_data   (spi_w_data),
    .spi_w_conf   (spi_w_conf),
    .spi_ss_in    (spi_ss_in),
    .spi_busy     (spi_busy)
  );

  typedef struct {
    string       name;
    logic        err;
    logic [7:0]  r1;
    logic [31:0] ext;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_tx[$];
  logic [7:0] rsp_q[$];

  int   tests = 0;
  int   fails = 0;
  int   busy_len = 2;
  bit   slave_dead = 1'b0;
  int   done_cnt = 0;
  int   conf_cnt = 0;
  int   ss_cnt = 0;
  logic [7:0] conf_data = '0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Result monitor plus strobe counters.
  always @(negedge clk) begin
    if (spi_w_conf) begin
      conf_cnt++;
      conf_data = spi_data_in;
    end
    if (spi_ss_in) ss_cnt++;
    if (done) begin
      exp_t e;
      done_cnt++;
      check_output("done_busy_low", {31'd0, busy}, 32'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_done: got done=1, expected none");
      end else begin
        e = exp_q.pop_front();
        check_output({e.name, "_err"}, {31'd0, err_timeout}, {31'd0, e.err});
        check_output({e.name, "_r1"}, {24'd0, resp_r1}, {24'd0, e.r1});
        check_output({e.name, "_ext"}, resp_ext, e.ext);
      end
    end
  end

  // SPI byte-master model: checks each transmitted byte, then answers.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (spi_w_data) begin
        if (exp_tx.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_tx: got byte 0x%0h, expected none", spi_data_in);
        end else begin
          check_output("tx_byte", {24'd0, spi_data_in}, {24'd0, exp_tx.pop_front()});
        end
        if (!slave_dead) begin
          @(posedge clk);
          #1 spi_busy = 1'b1;
          repeat (busy_len) @(posedge clk);
          #1;
          spi_data_out = (rsp_q.size() != 0) ? rsp_q.pop_front() : 8'hFF;
          spi_busy     = 1'b0;
        end
      end
    end
  end

  task automatic push_tx(input logic [5:0] i, input logic [31:0] a, input logic [6:0] c, input int fills);
    exp_tx.push_back({2'b01, i});
    exp_tx.push_back(a[31:24]);
    exp_tx.push_back(a[23:16]);
    exp_tx.push_back(a[15:8]);
    exp_tx.push_back(a[7:0]);
    exp_tx.push_back({c, 1'b1});
    for (int k = 0; k < fills; k++) exp_tx.push_back(8'hFF);
  endtask

  task automatic apply_stimulus(input logic [5:0] i, input logic [31:0] a, input logic [6:0] c, input logic e);
    @(posedge clk);
    #1;
    cmd_index = i;
    cmd_arg   = a;
    cmd_crc   = c;
    cmd_ext   = e;
    cmd_start = 1'b1;
    @(posedge clk);
    #1 cmd_start = 1'b0;
    check_output("busy_rise", {31'd0, busy}, 32'd1);
  endtask

  task automatic apply_init(input logic [7:0] div, input logic with_cmd);
    @(posedge clk);
    #1;
    clk_div    = div;
    init_start = 1'b1;
    cmd_start  = with_cmd;
    @(posedge clk);
    #1;
    init_start = 1'b0;
    cmd_start  = 1'b0;
    check_output("init_busy_rise", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(input string name, input int limit, output int n);
    int start_cnt;
    start_cnt = done_cnt;
    n = 0;
    while (done_cnt == start_cnt && n < limit) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == start_cnt) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s_wait: got no done in %0d cycles, expected done", name, limit);
    end
    repeat (3) @(posedge clk);
    #1 check_output({name, "_tx_left"}, exp_tx.size(), 32'd0);
  endtask

  initial begin
    int n;
    #1000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #2;
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_done", {31'd0, done}, 32'd0);
    check_output("rst_err", {31'd0, err_timeout}, 32'd0);
    check_output("rst_r1", {24'd0, resp_r1}, 32'hFF);
    check_output("rst_ext", resp_ext, 32'd0);
    check_output("rst_strobes", {29'd0, spi_w_data, spi_w_conf, spi_ss_in}, 32'd0);
    check_output("rst_data_in", {24'd0, spi_data_in}, 32'd0);
    rst = 1'b1;

    // Init: one conf cycle carrying the divider, then P_INIT cycles of ss_in.
    conf_cnt = 0;
    ss_cnt = 0;
    exp_q.push_back('{"init", 1'b0, 8'hFF, 32'd0});
    apply_init(8'h03, 1'b0);
    wait_done("init", 100, n);
    check_output("init_conf_cycles", conf_cnt, 32'd1);
    check_output("init_conf_data", {24'd0, conf_data}, 32'h03);
    check_output("init_ss_cycles", ss_cnt, 32'd16);

    // CMD0 with one-cycle busy glitches; R1 arrives on the third poll.
    ss_cnt = 0;
    busy_len = 1;
    push_tx(6'd0, 32'd0, 7'h4A, 4);
    for (int k = 0; k < 6; k++) rsp_q.push_back(8'hFF);
    rsp_q.push_back(8'hFF);
    rsp_q.push_back(8'hFF);
    rsp_q.push_back(8'h01);
    exp_q.push_back('{"cmd0", 1'b0, 8'h01, 32'd0});
    apply_stimulus(6'd0, 32'd0, 7'h4A, 1'b0);
    wait_done("cmd0", 300, n);

    // CMD8 with R7 tail.
    busy_len = 3;
    rsp_q.delete();
    push_tx(6'd8, 32'h0000_01AA, 7'h43, 6);
    for (int k = 0; k < 6; k++) rsp_q.push_back(8'hFF);
    rsp_q.push_back(8'h01);
    rsp_q.push_back(8'h00);
    rsp_q.push_back(8'h00);
    rsp_q.push_back(8'h01);
    rsp_q.push_back(8'hAA);
    exp_q.push_back('{"cmd8", 1'b0, 8'h01, 32'h0000_01AA});
    apply_stimulus(6'd8, 32'h0000_01AA, 7'h43, 1'b1);
    wait_done("cmd8", 400, n);

    // Poll exhaustion: exactly P_POLL fill bytes, no EXT or GAP.
    busy_len = 2;
    rsp_q.delete();
    push_tx(6'd55, 32'd0, 7'h32, P_POLL);
    exp_q.push_back('{"poll_to", 1'b1, 8'hFF, 32'h0000_01AA});
    apply_stimulus(6'd55, 32'd0, 7'h32, 1'b1);
    wait_done("poll_to", 400, n);
    check_output("cmd_ss_low", ss_cnt, 32'd0);

    // Lost handshake: only the first byte goes out, then the timeout fires.
    slave_dead = 1'b1;
    exp_tx.push_back(8'h51);
    exp_q.push_back('{"lost_hs", 1'b1, 8'hFF, 32'h0000_01AA});
    apply_stimulus(6'd17, 32'h1234_5678, 7'h2A, 1'b0);
    wait_done("lost_hs", 200, n);
    check_output("lost_hs_latency_ok", {31'd0, (n >= P_TO && n <= P_TO + 4)}, 32'd1);
    slave_dead = 1'b0;

    // Reset in the middle of a frame.
    push_tx(6'd0, 32'd0, 7'h4A, 4);
    apply_stimulus(6'd0, 32'd0, 7'h4A, 1'b0);
    repeat (8) @(posedge clk);
    #1 rst = 1'b0;
    #2;
    check_output("midrst_busy", {31'd0, busy}, 32'd0);
    check_output("midrst_err", {31'd0, err_timeout}, 32'd0);
    check_output("midrst_r1", {24'd0, resp_r1}, 32'hFF);
    check_output("midrst_ext", resp_ext, 32'd0);
    check_output("midrst_w_data", {31'd0, spi_w_data}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (20) @(posedge clk);
    exp_tx.delete();
    rsp_q.delete();

    // Clean CMD0 after reset.
    push_tx(6'd0, 32'd0, 7'h4A, 2);
    for (int k = 0; k < 6; k++) rsp_q.push_back(8'hFF);
    rsp_q.push_back(8'h01);
    exp_q.push_back('{"cmd0_again", 1'b0, 8'h01, 32'd0});
    apply_stimulus(6'd0, 32'd0, 7'h4A, 1'b0);
    wait_done("cmd0_again", 300, n);

    // cmd_start pulsed mid-command must be ignored.
    push_tx(6'd8, 32'h0000_01AA, 7'h43, 6);
    for (int k = 0; k < 6; k++) rsp_q.push_back(8'hFF);
    rsp_q.push_back(8'h01);
    rsp_q.push_back(8'h00);
    rsp_q.push_back(8'h00);
    rsp_q.push_back(8'h01);
    rsp_q.push_back(8'hAA);
    exp_q.push_back('{"cmd8_busy", 1'b0, 8'h01, 32'h0000_01AA});
    apply_stimulus(6'd8, 32'h0000_01AA, 7'h43, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    cmd_index = 6'd1;
    cmd_start = 1'b1;
    @(posedge clk);
    #1 cmd_start = 1'b0;
    wait_done("cmd8_busy", 400, n);

    // init_start and cmd_start together: only init runs.
    rsp_q.delete();
    conf_cnt = 0;
    ss_cnt = 0;
    cmd_index = 6'd0;
    exp_q.push_back('{"init_prio", 1'b0, 8'h01, 32'h0000_01AA});
    apply_init(8'h05, 1'b1);
    wait_done("init_prio", 100, n);
    check_output("prio_conf_cycles", conf_cnt, 32'd1);
    check_output("prio_conf_data", {24'd0, conf_data}, 32'h05);
    check_output("prio_ss_cycles", ss_cnt, 32'd16);
    check_output("results_left", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
